rom_access_arbiter: RTL and testbench
=====================================

# rom_access_arbiter

Two-port arbiter and sequencer for the 16 KB example-program ROM. It shares the ROM's single combinational read port between the CPU fetch/load path and the debug memory-dump path. It decodes 16-bit CPU-space addresses into the ROM window `$C000`–`$FFFF` and drives the ROM's `cs`/`oe`/`addr`. It returns registered read data with a per-port valid pulse, using CPU-priority arbitration with a starvation guard for the debug port.

## Interface
- `ADDR_WIDTH`, default 14: ROM address width; window base is `16'hC000`.
- `DATA_WIDTH`, default 8: ROM data width.
- `STARVE_LIMIT`, default 4: consecutive CPU grants, while debug is waiting, before debug is forced.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU read request; hold with `cpu_addr` stable until `cpu_gnt`.
- `cpu_addr`  in  16  CPU-space address.
- `cpu_gnt`  out  1  combinational; request accepted this cycle.
- `cpu_rvalid`  out  1  one-cycle pulse; `cpu_rdata` valid.
- `cpu_rdata`  out  DATA_WIDTH  registered read data.
- `dbg_req`, `dbg_addr`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the CPU port, for the debug requester.
- `decode_err`  out  1  one-cycle pulse with `rvalid` when the granted address was outside the window.
- `rom_addr`  out  ADDR_WIDTH  latched address `[ADDR_WIDTH-1:0]`.
- `rom_cs`, `rom_oe`  out  1  both asserted only in ACCESS.
- `rom_data`  in  DATA_WIDTH  ROM output; high-Z outside ACCESS and never sampled there.
- `busy`  out  1  high in ACCESS.

## Operation
- FSM has two states: IDLE and ACCESS.
- **IDLE:**
  - If any request is present, arbitrate, assert exactly one `gnt`, latch the address and owner, and go to ACCESS.
  - If no request is present, stay in IDLE.
- **Arbitration:**
  - CPU wins by default.
  - Debug wins if only `dbg_req` is high, or if `starve_cnt == STARVE_LIMIT`.
- **Starvation counter `starve_cnt`** (width `$clog2(STARVE_LIMIT+1)`):
  - Increments on each CPU grant while `dbg_req` is high.
  - Clears on a debug grant or whenever `dbg_req` is low.
  - Never exceeds `STARVE_LIMIT`.
- **Address decode:** in window iff `addr[15:14] == 2'b11`. `rom_addr = addr[13:0]`.
- **ACCESS, in window:**
  - `rom_cs = rom_oe = 1`.
  - `rom_data` is captured into the owner's `rdata` at the end of the cycle.
- **ACCESS, out of window:**
  - `rom_cs = rom_oe = 0`.
  - Owner's `rdata <= 8'hFF`.
  - `decode_err` pulses with `rvalid`.
- ACCESS always returns to IDLE after one cycle.
- The owner's `rvalid` pulses in the following cycle, which is an IDLE cycle; a new grant may occur in that same cycle.
- The non-owner's `rdata` holds its previous value.
- **Reset values:**
  - State IDLE.
  - All `gnt`, `rvalid`, `decode_err`, `rom_cs`, `rom_oe`, `busy` = 0.
  - `rom_addr` = 0, both `rdata` = 0, `starve_cnt` = 0.
- **Reset mid-ACCESS:** the transaction is dropped and no `rvalid` is issued.
- A `req` deasserted before `gnt` is simply not serviced. No request is queued.

## Timing
- Grant in cycle N (IDLE) → ROM access in N+1 (ACCESS) → `rvalid`/`rdata` in N+2.
- Peak throughput: one access per 2 cycles. Back-to-back grants land at N and N+2.
- `gnt` is combinational from `req`, state and `starve_cnt`. `rvalid`, `rdata`, `decode_err` and ROM controls are registered or decoded from state.
- Simultaneous requests at `starve_cnt < STARVE_LIMIT`: CPU is granted, debug waits.
- With both requesting continuously and `STARVE_LIMIT = 4`, the grant sequence is C,C,C,C,D,C,C,C,C,D…

## Configuration
- `ROM_ARB_STATS_EN`:
  - When defined, adds outputs `cpu_grant_cnt[15:0]` and `dbg_grant_cnt[15:0]`.
  - Each counts grants for its port, saturates at `16'hFFFF` and resets to 0.
  - When undefined, these ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- Reset, then CPU reads `$C001` → `cpu_gnt` at N, `rom_cs`/`rom_oe` high at N+1 with `rom_addr = 14'h0001`, `cpu_rvalid` at N+2 with `cpu_rdata = 8'hA9`.
- Debug reads `$FFFC` then `$FFFD` back-to-back → `dbg_rdata = 8'h00`, then `8'hC0`, with `rvalid` at N+2 and N+4.
- Both ports hold `req` for 20 cycles with `STARVE_LIMIT = 4` → grant order C,C,C,C,D repeating. CPU `rdata` never changes on debug completions, and vice versa.
- CPU reads `$8000` → no `rom_cs`, `cpu_rdata = 8'hFF`, `decode_err` pulses at N+2 together with `cpu_rvalid`.
- `rst` asserted during ACCESS → next cycle IDLE, all outputs at reset values, no `rvalid`. A subsequent `$C003` read returns `8'h69`.
- With `ROM_ARB_STATS_EN`: 3 CPU reads and 2 debug reads → `cpu_grant_cnt = 3`, `dbg_grant_cnt = 2`.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// Two-port (CPU/debug) arbiter for the single-ported 16 KB program ROM at $C000-$FFFF.
// Optional macro ROM_ARB_STATS_EN adds saturating per-port grant counters.
module rom_access_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_req,
    input  logic [15:0]           i_cpu_addr,
    output logic                  o_cpu_gnt,
    output logic                  o_cpu_rvalid,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    input  logic                  i_dbg_req,
    input  logic [15:0]           i_dbg_addr,
    output logic                  o_dbg_gnt,
    output logic                  o_dbg_rvalid,
    output logic [DATA_WIDTH-1:0] o_dbg_rdata,
    output logic                  o_decode_err,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    output logic                  o_rom_cs,
    output logic                  o_rom_oe,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic                  o_busy
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0]           o_cpu_grant_cnt,
    output logic [15:0]           o_dbg_grant_cnt
`endif
);

    localparam int            SW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_starve_cnt;
    logic                  r_owner_dbg;
    logic                  r_in_win;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_cpu_rvalid;
    logic                  r_dbg_rvalid;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_dbg_rdata;
    logic                  r_decode_err;
    logic                  w_gnt_cpu;
    logic                  w_gnt_dbg;
    logic [15:0]           w_sel_addr;
    logic [DATA_WIDTH-1:0] w_rd_val;

    // Debug takes the port when alone or once the CPU has starved it long enough.
    always_comb begin
        w_gnt_cpu   = 1'b0;
        w_gnt_dbg   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!i_rst) begin
                    if (i_dbg_req && (!i_cpu_req || r_starve_cnt == LIM)) begin
                        w_gnt_dbg = 1'b1;
                    end else if (i_cpu_req) begin
                        w_gnt_cpu = 1'b1;
                    end
                end
                if (w_gnt_cpu || w_gnt_dbg) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_sel_addr = w_gnt_dbg ? i_dbg_addr : i_cpu_addr;
    assign w_rd_val   = r_in_win ? i_rom_data : {DATA_WIDTH{1'b1}};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_owner_dbg  <= 1'b0;
            r_in_win     <= 1'b0;
            r_rom_addr   <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_decode_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_decode_err <= 1'b0;
            if (w_gnt_cpu || w_gnt_dbg) begin
                r_rom_addr  <= w_sel_addr[ADDR_WIDTH-1:0];
                r_owner_dbg <= w_gnt_dbg;
                r_in_win    <= (w_sel_addr[15:14] == 2'b11);
            end
            // ROM data is only sampled at the end of an in-window ACCESS cycle.
            if (r_state == ACCESS) begin
                r_decode_err <= !r_in_win;
                if (r_owner_dbg) begin
                    r_dbg_rvalid <= 1'b1;
                    r_dbg_rdata  <= w_rd_val;
                end else begin
                    r_cpu_rvalid <= 1'b1;
                    r_cpu_rdata  <= w_rd_val;
                end
            end
            if (!i_dbg_req || w_gnt_dbg) begin
                r_starve_cnt <= '0;
            end else if (w_gnt_cpu && r_starve_cnt != LIM) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end

`ifdef ROM_ARB_STATS_EN
    logic [15:0] r_cpu_grant_cnt;
    logic [15:0] r_dbg_grant_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cpu_grant_cnt <= '0;
            r_dbg_grant_cnt <= '0;
        end else begin
            if (w_gnt_cpu && r_cpu_grant_cnt != 16'hFFFF) begin
                r_cpu_grant_cnt <= r_cpu_grant_cnt + 16'd1;
            end
            if (w_gnt_dbg && r_dbg_grant_cnt != 16'hFFFF) begin
                r_dbg_grant_cnt <= r_dbg_grant_cnt + 16'd1;
            end
        end
    end

    assign o_cpu_grant_cnt = r_cpu_grant_cnt;
    assign o_dbg_grant_cnt = r_dbg_grant_cnt;
`endif

    assign o_cpu_gnt    = w_gnt_cpu;
    assign o_dbg_gnt    = w_gnt_dbg;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_dbg_rvalid = r_dbg_rvalid;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_dbg_rdata  = r_dbg_rdata;
    assign o_decode_err = r_decode_err;
    assign o_rom_addr   = r_rom_addr;
    assign o_busy       = (r_state == ACCESS);
    assign o_rom_cs     = (r_state == ACCESS) && r_in_win;
    assign o_rom_oe     = (r_state == ACCESS) && r_in_win;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: per-cycle vector table plus starvation, reset and read sequences.
module tb_rom_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, dbg_req;
    logic [15:0] cpu_addr, dbg_addr;
    logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
    logic [7:0]  cpu_rdata, dbg_rdata;
    logic        decode_err, rom_cs, rom_oe, busy;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
`ifdef ROM_ARB_STATS_EN
    logic [15:0] cpu_grant_cnt, dbg_grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rom_access_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .o_cpu_gnt(cpu_gnt),
        .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .o_dbg_gnt(dbg_gnt),
        .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
        .o_decode_err(decode_err), .o_rom_addr(rom_addr), .o_rom_cs(rom_cs),
        .o_rom_oe(rom_oe), .i_rom_data(rom_data), .o_busy(busy)
`ifdef ROM_ARB_STATS_EN
        , .o_cpu_grant_cnt(cpu_grant_cnt), .o_dbg_grant_cnt(dbg_grant_cnt)
`endif
    );

    // ROM contents; outside a selected access the bus carries junk that must never be captured.
    function automatic logic [7:0] rom_f(input logic [13:0] a);
        case (a)
            14'h0001: rom_f = 8'hA9;
            14'h0003: rom_f = 8'h69;
            14'h3FFC: rom_f = 8'h00;
            14'h3FFD: rom_f = 8'hC0;
            default:  rom_f = a[7:0] ^ 8'h3C;
        endcase
    endfunction

    assign rom_data = rom_cs ? rom_f(rom_addr) : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        creq;
        logic [15:0] caddr;
        logic        dreq;
        logic [15:0] daddr;
        logic        cgnt, dgnt, busy, cs;
        logic [13:0] raddr;
        logic        crv;
        logic [7:0]  crd;
        logic        drv;
        logic [7:0]  drd;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    // One full transaction starting from IDLE with no other requester.
    task automatic do_read(input logic is_dbg, input logic [15:0] addr, input logic [7:0] exp_data);
        logic in_win;
        in_win = (addr[15:14] == 2'b11);
        @(negedge clk);
        cpu_req = !is_dbg; cpu_addr = addr;
        dbg_req = is_dbg;  dbg_addr = addr;
        #1;
        chk("rd_cpu_gnt", cpu_gnt, !is_dbg);
        chk("rd_dbg_gnt", dbg_gnt, is_dbg);
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0;
        #1;
        chk("rd_busy", busy, 1);
        chk("rd_cs", rom_cs, in_win);
        chk("rd_oe", rom_oe, in_win);
        chk("rd_rom_addr", rom_addr, addr[13:0]);
        @(negedge clk);
        #1;
        chk("rd_rvalid", is_dbg ? dbg_rvalid : cpu_rvalid, 1);
        chk("rd_rdata", is_dbg ? dbg_rdata : cpu_rdata, exp_data);
        chk("rd_decode_err", decode_err, !in_win);
    endtask

    initial begin
        logic [7:0] exp_crd, exp_drd;
        logic       expd, pd, e_crv, e_drv;

        //            creq caddr     dreq daddr     cgnt dgnt busy cs raddr     crv crd    drv drd    err
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 16'hC001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0001, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0001, 1'b1, 8'hA9, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFC, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0001, 1'b0, 8'hA9, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b1, 1'b1, 14'h3FFC, 1'b0, 8'hA9, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFD, 1'b0, 1'b1, 1'b0, 1'b0, 14'h3FFC, 1'b0, 8'hA9, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 14'h3FFD, 1'b0, 8'hA9, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 14'h3FFD, 1'b0, 8'hA9, 1'b1, 8'hC0, 1'b0};
        vecs[9]  = '{1'b1, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 14'h3FFD, 1'b0, 8'hA9, 1'b0, 8'hC0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 1'b0, 8'hA9, 1'b0, 8'hC0, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 8'hFF, 1'b0, 8'hC0, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 8'hFF, 1'b0, 8'hC0, 1'b0};

        // Reset with a CPU request pending: no grant may leak out during reset.
        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 16'hC001; dbg_req = 1'b0; dbg_addr = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cs", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        rst = 1'b0; cpu_req = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            cpu_req = vecs[i].creq; cpu_addr = vecs[i].caddr;
            dbg_req = vecs[i].dreq; dbg_addr = vecs[i].daddr;
            #1;
            chk($sformatf("v%0d_cpu_gnt", i), cpu_gnt, vecs[i].cgnt);
            chk($sformatf("v%0d_dbg_gnt", i), dbg_gnt, vecs[i].dgnt);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d_rom_cs", i), rom_cs, vecs[i].cs);
            chk($sformatf("v%0d_rom_oe", i), rom_oe, vecs[i].cs);
            chk($sformatf("v%0d_rom_addr", i), rom_addr, vecs[i].raddr);
            chk($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].crv);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].crd);
            chk($sformatf("v%0d_dbg_rvalid", i), dbg_rvalid, vecs[i].drv);
            chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, vecs[i].drd);
            chk($sformatf("v%0d_decode_err", i), decode_err, vecs[i].err);
        end

        // Both ports request continuously: grants every other cycle, every fifth goes to debug.
        cpu_addr = 16'hC010; dbg_addr = 16'hC020;
        exp_crd = 8'hFF; exp_drd = 8'hC0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            cpu_req = (c < 40); dbg_req = (c < 40);
            #1;
            if (c < 40 && c % 2 == 0) begin
                expd = ((c / 2) % 5 == 4);
                chk($sformatf("starve_c%0d_cpu_gnt", c), cpu_gnt, !expd);
                chk($sformatf("starve_c%0d_dbg_gnt", c), dbg_gnt, expd);
            end else begin
                chk($sformatf("starve_c%0d_cpu_gnt", c), cpu_gnt, 0);
                chk($sformatf("starve_c%0d_dbg_gnt", c), dbg_gnt, 0);
            end
            e_crv = 1'b0; e_drv = 1'b0;
            if (c >= 2 && c % 2 == 0) begin
                pd = (((c - 2) / 2) % 5 == 4);
                if (pd) begin e_drv = 1'b1; exp_drd = 8'h1C; end
                else    begin e_crv = 1'b1; exp_crd = 8'h2C; end
            end
            chk($sformatf("starve_c%0d_cpu_rvalid", c), cpu_rvalid, e_crv);
            chk($sformatf("starve_c%0d_dbg_rvalid", c), dbg_rvalid, e_drv);
            chk($sformatf("starve_c%0d_cpu_rdata", c), cpu_rdata, exp_crd);
            chk($sformatf("starve_c%0d_dbg_rdata", c), dbg_rdata, exp_drd);
        end

        // Reset arriving during ACCESS drops the transaction.
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 16'hC005; dbg_req = 1'b0;
        #1;
        chk("mid_cpu_gnt", cpu_gnt, 1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("mid_busy", busy, 1);
        rst = 1'b1; cpu_req = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cs", rom_cs, 0);
        chk("mid_rst_cpu_gnt", cpu_gnt, 0);
        chk("mid_rst_cpu_rvalid", cpu_rvalid, 0);
        chk("mid_rst_dbg_rvalid", dbg_rvalid, 0);
        chk("mid_rst_decode_err", decode_err, 0);
        chk("mid_rst_cpu_rdata", cpu_rdata, 0);
        chk("mid_rst_dbg_rdata", dbg_rdata, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        rst = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_cpu_rvalid", cpu_rvalid, 0);
        chk("post_rst_busy", busy, 0);

        do_read(1'b0, 16'hC003, 8'h69);
        do_read(1'b0, 16'hC000, 8'h3C);
        do_read(1'b1, 16'hBFFF, 8'hFF);
        do_read(1'b1, 16'hFFFD, 8'hC0);
        do_read(1'b0, 16'hC002, 8'h3E);
        chk("final_dbg_rdata_held", dbg_rdata, 8'hC0);

`ifdef ROM_ARB_STATS_EN
        chk("stats_cpu_grant_cnt", cpu_grant_cnt, 3);
        chk("stats_dbg_grant_cnt", dbg_grant_cnt, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
